latch_write_arbiter: RTL and testbench

//   Round-robin arbiter and enable sequencer for a shared level-sensitive D latch bank

---
 rtl/latch_write_arbiter.sv | 138 +++++++++++++
 tb/tb_latch_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_write_arbiter.sv
// Round-robin write arbiter and enable sequencer for a shared D latch bank.
// Each write walks SETUP -> OPEN -> HOLD so latch_data is stable before
// latch_en rises and after it falls. A clear request pulses latch_rst_n low
// for one cycle. Every output is driven straight from a flop.
module latch_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int OPEN_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      clr_req,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      clr_ack,
    output logic                      busy,
    output logic [DATA_W-1:0]         latch_data,
    output logic                      latch_en,
    output logic                      latch_rst_n
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] OPEN  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] CLEAR = 3'd4;

    logic [2:0]        state;
    logic [IDX_W-1:0]  last_winner;
    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W-1:0]  cand;
    logic [CNT_W-1:0]  open_cnt;
    logic [DATA_W-1:0] win_data;

    // Rotating-priority search: first set req bit above last_winner, wrapping.
    // Scanning from the farthest candidate down lets the nearest one win.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        arb_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_winner) + k) % NUM_REQ);
            if (req[cand]) begin
                arb_idx = cand;
            end
        end
    end

    // Select the arbitration winner's data word.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Phase sequencer: state, grant, latch pins and priority pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before this edge, whatever the statement order.
        if (reset) begin
            state       <= IDLE;
            last_winner <= IDX_W'(NUM_REQ - 1);
            open_cnt    <= '0;
            gnt         <= '0;
            done        <= '0;
            clr_ack     <= 1'b0;
            busy        <= 1'b0;
            latch_data  <= '0;
            latch_en    <= 1'b0;
            latch_rst_n <= 1'b0;
        end else begin
            // Pulses default low, and the bank reset is released.
            done        <= '0;
            clr_ack     <= 1'b0;
            latch_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        clr_ack     <= 1'b1;
                        latch_rst_n <= 1'b0;
                        latch_data  <= '0;
                    end else if (|req) begin
                        state      <= SETUP;
                        busy       <= 1'b1;
                        gnt        <= NUM_REQ'(1) << arb_idx;
                        latch_data <= win_data;
                    end
                end
                SETUP: begin
                    state    <= OPEN;
                    latch_en <= 1'b1;
                    open_cnt <= '0;
                end
                OPEN: begin
                    if (open_cnt == CNT_W'(OPEN_CYCLES - 1)) begin
                        state    <= HOLD;
                        latch_en <= 1'b0;
                        done     <= gnt;
                    end else begin
                        open_cnt <= open_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    gnt   <= '0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gnt[i]) begin
                            last_winner <= IDX_W'(i);
                        end
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    gnt      <= '0;
                    latch_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter. Two instances share one stimulus stream: one
// with OPEN_CYCLES=1 and one with OPEN_CYCLES=3. A transaction-timeline model
// predicts every output each cycle, and directed literal checks pin the model.
module tb_latch_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic [N-1:0] req      = '0;
    logic [N*W-1:0] req_data = '0;
    logic         clr_req  = 1'b0;

    logic [N-1:0] gnt_a  [2];
    logic [N-1:0] done_a [2];
    logic         clr_ack_a [2];
    logic         busy_a [2];
    logic [W-1:0] data_a [2];
    logic         en_a   [2];
    logic         rstn_a [2];

    latch_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .OPEN_CYCLES(1)) dut_oc1 (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .clr_req(clr_req),
        .gnt(gnt_a[0]), .done(done_a[0]), .clr_ack(clr_ack_a[0]), .busy(busy_a[0]),
        .latch_data(data_a[0]), .latch_en(en_a[0]), .latch_rst_n(rstn_a[0])
    );

    latch_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .OPEN_CYCLES(3)) dut_oc3 (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .clr_req(clr_req),
        .gnt(gnt_a[1]), .done(done_a[1]), .clr_ack(clr_ack_a[1]), .busy(busy_a[1]),
        .latch_data(data_a[1]), .latch_en(en_a[1]), .latch_rst_n(rstn_a[1])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    function automatic int oc_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    // Model: mode 0 idle, 1 write (t = cycles since SETUP began), 2 clear.
    int           m_mode [2];
    int           m_t    [2];
    int           m_win  [2];
    int           m_last [2];
    logic [W-1:0] m_data [2];
    logic         m_rstn [2];
    bit           started = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_mode[d] = 0; m_t[d] = 0; m_win[d] = 0; m_last[d] = N - 1;
                m_data[d] = '0; m_rstn[d] = 1'b0;
            end else begin
                m_rstn[d] = 1'b1;
                case (m_mode[d])
                    0: begin
                        if (clr_req) begin
                            m_mode[d] = 2; m_data[d] = '0; m_rstn[d] = 1'b0;
                        end else if (req != '0) begin
                            m_win[d]  = pick(m_last[d], req);
                            m_data[d] = req_data[m_win[d]*W +: W];
                            m_mode[d] = 1; m_t[d] = 0;
                        end
                    end
                    1: begin
                        m_t[d]++;
                        if (m_t[d] > oc_of(d) + 1) begin
                            m_mode[d] = 0; m_last[d] = m_win[d];
                        end
                    end
                    default: m_mode[d] = 0;
                endcase
            end
        end
        if (reset) started = 1'b1;
    end

    // Every-cycle comparison of both DUTs against the model.
    logic [31:0] e_gnt, e_done, e_en;
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                e_gnt  = (m_mode[d] == 1) ? (32'd1 << m_win[d]) : 32'd0;
                e_en   = (m_mode[d] == 1 && m_t[d] >= 1 && m_t[d] <= oc_of(d)) ? 32'd1 : 32'd0;
                e_done = (m_mode[d] == 1 && m_t[d] == oc_of(d) + 1) ? e_gnt : 32'd0;
                check("m_gnt", d, 32'(gnt_a[d]), e_gnt);
                check("m_done", d, 32'(done_a[d]), e_done);
                check("m_latch_en", d, 32'(en_a[d]), e_en);
                check("m_busy", d, 32'(busy_a[d]), 32'(m_mode[d] != 0));
                check("m_clr_ack", d, 32'(clr_ack_a[d]), 32'(m_mode[d] == 2));
                check("m_latch_rst_n", d, 32'(rstn_a[d]), 32'(m_rstn[d]));
                check("m_latch_data", d, 32'(data_a[d]), 32'(m_data[d]));
            end
        end
    end

    // Event recorder used by the directed checks.
    int           cyc_n = 0;
    int           g_idx_q [$];
    int           g_cyc_q [$];
    logic [W-1:0] g_dat_q [$];
    logic [N-1:0] prev_g = '0;
    int           done0_cnt = 0;
    int           en3_cnt = 0;
    int           done3_cnt = 0;

    always @(negedge clk) begin
        cyc_n++;
        if (gnt_a[0] != '0 && prev_g == '0) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_a[0][i]) g_idx_q.push_back(i);
            end
            g_cyc_q.push_back(cyc_n);
            g_dat_q.push_back(data_a[0]);
        end
        prev_g = gnt_a[0];
        if (done_a[0] != '0) done0_cnt++;
        if (en_a[1]) en3_cnt++;
        if (done_a[1] == 4'b0100) done3_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        clr_req = 1'b0;
        repeat (n) cyc();
    endtask

    int base;
    int snap_a;
    int snap_b;

    initial begin
        // 1: reset held three cycles, then released.
        repeat (3) begin
            cyc();
            check("rst_latch_rst_n", 0, 32'(rstn_a[0]), 32'd0);
            check("rst_busy", 0, 32'(busy_a[0]), 32'd0);
        end
        reset = 1'b0;
        cyc();
        check("rel_latch_rst_n", 0, 32'(rstn_a[0]), 32'd1);
        check("rel_gnt", 0, 32'(gnt_a[0]), 32'd0);
        check("rel_latch_data", 0, 32'(data_a[0]), 32'd0);

        // 2: single write from requester 1.
        req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
        req = 4'b0010;
        cyc();
        check("w1_setup_gnt", 0, 32'(gnt_a[0]), 32'h2);
        check("w1_setup_data", 0, 32'(data_a[0]), 32'hA5);
        check("w1_setup_en", 0, 32'(en_a[0]), 32'd0);
        req = '0;
        cyc();
        check("w1_open_en", 0, 32'(en_a[0]), 32'd1);
        cyc();
        check("w1_hold_done", 0, 32'(done_a[0]), 32'h2);
        check("w1_hold_en", 0, 32'(en_a[0]), 32'd0);
        cyc();
        check("w1_idle_gnt", 0, 32'(gnt_a[0]), 32'd0);
        check("w1_idle_data", 0, 32'(data_a[0]), 32'hA5);
        idle(8);

        // 3: all requesters held after a fresh reset -> 0,1,2,3,0.
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        base = g_idx_q.size();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'hF;
        repeat (18) cyc();
        idle(10);
        check("rr_writes", 0, 32'(g_idx_q.size() - base), 32'd5);
        for (int j = 0; j < 5 && base + j < g_idx_q.size(); j++) begin
            check("rr_winner", 0, 32'(g_idx_q[base+j]), 32'(j % 4));
            check("rr_data", 0, 32'(g_dat_q[base+j]), 32'h11 * 32'(j % 4 + 1));
            if (j > 0) check("rr_gap", 0, 32'(g_cyc_q[base+j] - g_cyc_q[base+j-1]), 32'd4);
        end

        // 4: clear and write requested together -> clear first.
        req_data[7:0] = 8'h5A;
        clr_req = 1'b1;
        req = 4'b0001;
        cyc();
        check("clr_ack", 0, 32'(clr_ack_a[0]), 32'd1);
        check("clr_latch_rst_n", 0, 32'(rstn_a[0]), 32'd0);
        check("clr_latch_data", 0, 32'(data_a[0]), 32'd0);
        check("clr_gnt", 0, 32'(gnt_a[0]), 32'd0);
        clr_req = 1'b0;
        cyc();
        check("clr_after_busy", 0, 32'(busy_a[0]), 32'd0);
        cyc();
        check("clr_then_gnt", 0, 32'(gnt_a[0]), 32'h1);
        check("clr_then_data", 0, 32'(data_a[0]), 32'h5A);
        idle(10);

        // 5: reset during OPEN aborts the write; priority restarts at 0.
        snap_a = done0_cnt;
        req = 4'b0001;
        cyc(); cyc();
        check("abort_open_en", 0, 32'(en_a[0]), 32'd1);
        reset = 1'b1;
        req = '0;
        cyc();
        check("abort_en", 0, 32'(en_a[0]), 32'd0);
        check("abort_gnt", 0, 32'(gnt_a[0]), 32'd0);
        check("abort_busy", 0, 32'(busy_a[0]), 32'd0);
        check("abort_latch_rst_n", 0, 32'(rstn_a[0]), 32'd0);
        reset = 1'b0;
        cyc(); cyc();
        check("abort_no_done", 0, 32'(done0_cnt - snap_a), 32'd0);
        base = g_idx_q.size();
        req = 4'hF;
        cyc();
        idle(10);
        check("abort_grant_seen", 0, 32'(g_idx_q.size() > base), 32'd1);
        if (g_idx_q.size() > base) check("abort_first_winner", 0, 32'(g_idx_q[base]), 32'd0);

        // 6: OPEN_CYCLES=3, requester 2 drops req in SETUP.
        snap_a = en3_cnt;
        snap_b = done3_cnt;
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        cyc();
        check("oc3_setup_gnt", 1, 32'(gnt_a[1]), 32'h4);
        req = '0;
        repeat (10) cyc();
        check("oc3_en_cycles", 1, 32'(en3_cnt - snap_a), 32'd3);
        check("oc3_done_pulses", 1, 32'(done3_cnt - snap_b), 32'd1);
        check("oc3_data", 1, 32'(data_a[1]), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
